// File: rtl/nock_increment_pkg.sv
`default_nettype none
// ============================================================================
// nock_increment_pkg : shared codes for the Nock increment execution unit
// Revision 1.0
// ============================================================================
package nock_increment_pkg;

    // Memory unit function codes
    localparam logic [1:0] SET_CONTENTS = 2'b01;

    // Tag [1:0] cell/atom encoding: bit 1 = hed is cell, bit 0 = tel is cell
    localparam logic [1:0] ATOM_ATOM = 2'b00;
    localparam logic [1:0] ATOM_CELL = 2'b01;

    // Traversal engine mux selection for an increment frame
    localparam logic [3:0] MUX_INCR = 4'h4;

    // Tag bit positions
    localparam int TAG_EXEC_BIT  = 7;
    localparam int TAG_VISIT_HI  = 3;
    localparam int TAG_VISIT_LO  = 2;
    localparam int TAG_TEL_CELL  = 0;

    // Sticky error codes
    localparam logic [7:0] ERR_NONE         = 8'h00;
    localparam logic [7:0] ERR_CELL_OPERAND = 8'h01;
    localparam logic [7:0] ERR_BAD_OPCODE   = 8'h02;
    localparam logic [7:0] ERR_OVERFLOW     = 8'h03;

    // Continuation handed back to the traversal engine
    localparam logic [3:0] SYS_TRAVERSE = 4'h2;
    localparam logic [3:0] STATE_POP    = 4'h2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WRITE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4,
        ST_HOLD   = 3'd5,
        ST_ERROR  = 3'd6
    } incr_state_t;

endpackage
`default_nettype wire

// File: rtl/nock_increment.sv
`default_nettype none
// ============================================================================
// nock_increment : Nock opcode 4 unit, increments an atom frame in place
// Revision 1.0
// ============================================================================
module nock_increment
    import nock_increment_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int NOUN_W = 28,
    parameter int TAG_W  = 8,
    parameter int DATA_W = TAG_W + 2 * NOUN_W,
    parameter int OPCODE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] module_address,
    input  logic [DATA_W-1:0] module_data,
    input  logic              mem_ready,
    output logic              mem_execute,
    output logic [1:0]        mem_func,
    output logic [ADDR_W-1:0] address1,
    output logic [DATA_W-1:0] write_data,
    output logic              module_finished,
    output logic [3:0]        execute_return_sys_func,
    output logic [3:0]        execute_return_state,
    output logic [7:0]        error
);

    incr_state_t       state;
    logic [ADDR_W-1:0] frame_addr;
    logic [TAG_W-1:0]  frame_tag;
    logic [NOUN_W-1:0] frame_hed;
    logic [NOUN_W-1:0] frame_tel;

    logic [NOUN_W-1:0] incremented;
    logic [TAG_W-1:0]  reduced_tag;

    // The reduced frame is a plain atom: no longer pending, visit marks cleared
    always_comb begin
        incremented = frame_tel + NOUN_W'(1);
        reduced_tag = frame_tag;
        reduced_tag[TAG_EXEC_BIT] = 1'b0;
        reduced_tag[TAG_VISIT_HI:TAG_VISIT_LO] = 2'b00;
        reduced_tag[1:0] = ATOM_ATOM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= ST_IDLE;
            frame_addr              <= '0;
            frame_tag               <= '0;
            frame_hed               <= '0;
            frame_tel               <= '0;
            mem_execute             <= 1'b0;
            mem_func                <= 2'b00;
            address1                <= '0;
            write_data              <= '0;
            module_finished         <= 1'b0;
            execute_return_sys_func <= 4'h0;
            execute_return_state    <= 4'h0;
            error                   <= ERR_NONE;
        end else begin
            mem_execute     <= 1'b0;
            mem_func        <= 2'b00;
            address1        <= '0;
            write_data      <= '0;
            module_finished <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        frame_addr              <= module_address;
                        frame_tag               <= module_data[DATA_W-1 -: TAG_W];
                        frame_hed               <= module_data[2*NOUN_W-1 -: NOUN_W];
                        frame_tel               <= module_data[NOUN_W-1:0];
                        execute_return_sys_func <= 4'h0;
                        execute_return_state    <= 4'h0;
                        state                   <= ST_DECODE;
                    end
                end

                // Request is issued on entry to WRITE so it is registered there
                ST_DECODE: begin
                    if (frame_hed != NOUN_W'(OPCODE)) begin
                        error <= ERR_BAD_OPCODE;
                        state <= ST_ERROR;
                    end else if (frame_tag[TAG_TEL_CELL]) begin
                        error <= ERR_CELL_OPERAND;
                        state <= ST_ERROR;
                    end else if (&frame_tel) begin
                        error <= ERR_OVERFLOW;
                        state <= ST_ERROR;
                    end else begin
                        mem_execute <= 1'b1;
                        mem_func    <= SET_CONTENTS;
                        address1    <= frame_addr;
                        write_data  <= {reduced_tag, incremented, {NOUN_W{1'b0}}};
                        state       <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (mem_ready) begin
                        module_finished         <= 1'b1;
                        execute_return_sys_func <= SYS_TRAVERSE;
                        execute_return_state    <= STATE_POP;
                        state                   <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    state <= ST_HOLD;
                end

                // Wait for the mux to release us so one selection runs one frame
                ST_HOLD: begin
                    if (!start) begin
                        state <= ST_IDLE;
                    end
                end

                ST_ERROR: begin
                    state <= ST_ERROR;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nock_increment.sv
`default_nettype none
// ============================================================================
// tb_nock_increment : directed self-checking bench for nock_increment
// Revision 1.0
// ============================================================================
module tb_nock_increment;
    import nock_increment_pkg::*;

    localparam int ADDR_W = 11;
    localparam int NOUN_W = 28;
    localparam int TAG_W  = 8;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] module_address;
    logic [DATA_W-1:0] module_data;
    logic              mem_ready;
    logic              mem_execute;
    logic [1:0]        mem_func;
    logic [ADDR_W-1:0] address1;
    logic [DATA_W-1:0] write_data;
    logic              module_finished;
    logic [3:0]        execute_return_sys_func;
    logic [3:0]        execute_return_state;
    logic [7:0]        error;

    always #5 clk = ~clk;

    nock_increment #(
        .ADDR_W (ADDR_W),
        .NOUN_W (NOUN_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .OPCODE (4)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .module_address          (module_address),
        .module_data             (module_data),
        .mem_ready               (mem_ready),
        .mem_execute             (mem_execute),
        .mem_func                (mem_func),
        .address1                (address1),
        .write_data              (write_data),
        .module_finished         (module_finished),
        .execute_return_sys_func (execute_return_sys_func),
        .execute_return_state    (execute_return_state),
        .error                   (error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int               cyc     = 0;
    int               wr_cnt  = 0;
    int               fin_cnt = 0;
    int               wr_cyc  = 0;
    int               fin_cyc = 0;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        wr_func;
    logic [3:0]        fin_sys;
    logic [3:0]        fin_st;

    // Observe outputs 1 ns after each rising edge
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (mem_execute) begin
            wr_cnt  = wr_cnt + 1;
            wr_cyc  = cyc;
            wr_addr = address1;
            wr_data = write_data;
            wr_func = mem_func;
        end
        if (module_finished) begin
            fin_cnt = fin_cnt + 1;
            fin_cyc = cyc;
            fin_sys = execute_return_sys_func;
            fin_st  = execute_return_state;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_frame(input logic [7:0] tag, input logic [27:0] tel,
                            input logic [10:0] addr, input int lat, input int hold,
                            input bit early, input logic [7:0] exp_tag,
                            input logic [27:0] exp_hed);
        int w0, f0, t0, r0;
        w0 = wr_cnt;
        f0 = fin_cnt;
        @(negedge clk);
        start          = 1'b1;
        module_address = addr;
        module_data    = {tag, 28'd4, tel};
        t0             = cyc;
        for (int i = 0; i < 12 && wr_cnt == w0; i++) @(negedge clk);
        chk("wr_seen", 64'(wr_cnt - w0), 1);
        chk("wr_latency", 64'(wr_cyc - t0), 2);
        chk("wr_addr", 64'(wr_addr), 64'(addr));
        chk("wr_data", wr_data, {exp_tag, exp_hed, 28'd0});
        chk("wr_func", 64'(wr_func), 64'(SET_CONTENTS));
        if (early) start = 1'b0;
        repeat (lat + 1) @(negedge clk);
        mem_ready = 1'b1;
        r0        = cyc;
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 12 && fin_cnt == f0; i++) @(negedge clk);
        chk("fin_seen", 64'(fin_cnt - f0), 1);
        chk("fin_latency", 64'(fin_cyc - r0), 1);
        chk("ret_sys", 64'(fin_sys), 64'h2);
        chk("ret_state", 64'(fin_st), 64'h2);
        repeat (hold) @(negedge clk);
        chk("ret_hold", 64'(execute_return_sys_func), 64'h2);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("wr_once", 64'(wr_cnt - w0), 1);
        chk("fin_once", 64'(fin_cnt - f0), 1);
    endtask

    task automatic do_err(input logic [7:0] tag, input logic [27:0] hed,
                          input logic [27:0] tel, input logic [7:0] exp_err);
        int w0, f0;
        w0 = wr_cnt;
        f0 = fin_cnt;
        @(negedge clk);
        start          = 1'b1;
        module_address = 11'd20;
        module_data    = {tag, hed, tel};
        repeat (6) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_code", 64'(error), 64'(exp_err));
        chk("err_no_write", 64'(wr_cnt - w0), 0);
        chk("err_no_fin", 64'(fin_cnt - f0), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("err_cleared", 64'(error), 0);
    endtask

    initial begin
        int w0, f0;
        rst            = 1'b1;
        start          = 1'b0;
        mem_ready      = 1'b0;
        module_address = '0;
        module_data    = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_execute", 64'(mem_execute), 0);
        chk("rst_mem_func", 64'(mem_func), 0);
        chk("rst_address1", 64'(address1), 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_finished", 64'(module_finished), 0);
        chk("rst_ret_sys", 64'(execute_return_sys_func), 0);
        chk("rst_ret_state", 64'(execute_return_state), 0);
        chk("rst_error", 64'(error), 0);
        rst = 1'b0;

        do_frame(8'h80, 28'd41, 11'd5, 3, 0, 1'b0, 8'h00, 28'd42);
        do_frame(8'h7C, 28'd0, 11'd0, 0, 0, 1'b1, 8'h70, 28'd1);
        do_frame(8'hCE, 28'hFFFFFFE, 11'h7FE, 1, 0, 1'b0, 8'h40, 28'hFFFFFFF);

        do_err(8'h80, 28'd4, 28'hFFFFFFF, 8'h03);
        do_err(8'h81, 28'd4, 28'd41, 8'h01);
        do_err(8'h80, 28'd5, 28'd41, 8'h02);
        do_err(8'h81, 28'd5, 28'hFFFFFFF, 8'h02);

        do_frame(8'h80, 28'd100, 11'd9, 2, 20, 1'b0, 8'h00, 28'd101);
        do_frame(8'h80, 28'd7, 11'd9, 2, 0, 1'b0, 8'h00, 28'd8);

        // Abort an operation while it waits on memory
        w0 = wr_cnt;
        f0 = fin_cnt;
        @(negedge clk);
        start          = 1'b1;
        module_address = 11'd6;
        module_data    = {8'h80, 28'd4, 28'd50};
        for (int i = 0; i < 12 && wr_cnt == w0; i++) @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        #1;
        chk("abort_state", 64'(dut.state), 64'(ST_IDLE));
        chk("abort_mem_execute", 64'(mem_execute), 0);
        chk("abort_write_data", write_data, 0);
        chk("abort_finished", 64'(module_finished), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_late_ready_fin", 64'(fin_cnt - f0), 0);
        chk("abort_one_write", 64'(wr_cnt - w0), 1);
        chk("abort_error", 64'(error), 0);

        do_frame(8'h80, 28'd9, 11'd3, 1, 0, 1'b0, 8'h00, 28'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
